// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: SW sync/debounce, blink tick prescaler and tail-light state FSM (optional TSC_TIMEOUT_EN auto-cancel)
module turn_signal_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TICK_DIV        = 8,
   parameter int TIMEOUT_SEQS    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] SW,
   output logic [2:0] CurrentState,
   output logic       tick,
   output logic [1:0] step
);
   typedef enum logic [2:0] {
      IDLE       = 3'b000,
      HAZARDS    = 3'b001,
      TURN_LEFT  = 3'b010,
      TURN_RIGHT = 3'b011
   } state_t;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(TICK_DIV);
   logic [1:0]    s1, s2, cand, sw_db;
   logic [DW-1:0] db_cnt, db_nxt;
   logic [PW-1:0] pcnt;
   state_t        state, state_nxt, req;
   logic [1:0]    step_nxt;
`ifdef TSC_TIMEOUT_EN
   localparam int QW = $clog2(TIMEOUT_SEQS + 1);
   logic [QW-1:0] seq, seq_nxt;
   logic [1:0]    lock_sw;
   logic          lockout, lock_set, lock_hold;
   assign lock_hold = lockout && (sw_db == lock_sw);
`endif
   assign db_nxt       = (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) ? db_cnt : db_cnt + 1'b1;
   assign tick         = (pcnt == PW'(TICK_DIV - 1));
   assign CurrentState = state;
   assign req = (sw_db == 2'b11) ? HAZARDS :
                (sw_db == 2'b01) ? TURN_LEFT :
                (sw_db == 2'b10) ? TURN_RIGHT : IDLE;
   // two-flop synchroniser feeding a restart-on-change debounce counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1     <= 2'b00;
         s2     <= 2'b00;
         cand   <= 2'b00;
         sw_db  <= 2'b00;
         db_cnt <= '0;
      end else begin
         s1 <= SW;
         s2 <= s1;
         if (s2 != cand) begin
            cand   <= s2;
            db_cnt <= '0;
            if (DEBOUNCE_CYCLES == 1) sw_db <= s2;
         end else begin
            db_cnt <= db_nxt;
            if (db_nxt == DW'(DEBOUNCE_CYCLES - 1)) sw_db <= cand;
         end
      end
   end
   // free-running blink-step prescaler
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pcnt <= '0;
      else       pcnt <= tick ? '0 : pcnt + 1'b1;
   end
   // state register; timeout bookkeeping rides along when enabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         step  <= 2'd0;
`ifdef TSC_TIMEOUT_EN
         seq     <= '0;
         lockout <= 1'b0;
         lock_sw <= 2'b00;
`endif
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
`ifdef TSC_TIMEOUT_EN
         seq     <= (state_nxt != state) ? '0 : seq_nxt;
         lockout <= lock_set ? 1'b1 : (sw_db != lock_sw) ? 1'b0 : lockout;
         lock_sw <= lock_set ? sw_db : lock_sw;
`endif
      end
   end
   // next state: only tick cycles move; turn sequences finish before changing side
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
`ifdef TSC_TIMEOUT_EN
      seq_nxt  = seq;
      lock_set = 1'b0;
`endif
      if (tick) begin
         if (state == IDLE || state == HAZARDS) begin
`ifdef TSC_TIMEOUT_EN
            if (req != state && !(state == IDLE && lock_hold)) begin
`else
            if (req != state) begin
`endif
               state_nxt = req;
               step_nxt  = 2'd0;
            end
         end else if (req == HAZARDS || (req != state && step == 2'd3)) begin
            state_nxt = req;
            step_nxt  = 2'd0;
         end else begin
            step_nxt = step + 2'd1;
`ifdef TSC_TIMEOUT_EN
            if (req == state && step == 2'd3) begin
               if (seq == QW'(TIMEOUT_SEQS - 1)) begin
                  state_nxt = IDLE;
                  step_nxt  = 2'd0;
                  lock_set  = 1'b1;
               end else begin
                  seq_nxt = seq + 1'b1;
               end
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// tb_turn_signal_ctrl: directed checks of debounce latency, tick, turn/hazard sequencing and reset
module tb_turn_signal_ctrl;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] SW = 2'b00;
   logic [2:0] CurrentState;
   logic       tick;
   logic [1:0] step;
   int         errors = 0;
   int         checks = 0;

   turn_signal_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8), .TIMEOUT_SEQS(2)) dut (
      .clk(clk), .reset(reset), .SW(SW), .CurrentState(CurrentState), .tick(tick), .step(step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic to_tick(input string tag);
      int i = 0;
      while (!tick && i < 20) begin
         cyc(1);
         i++;
      end
      chk({tag, "_tick_seen"}, {3'b0, tick}, 4'h1);
      cyc(1);
   endtask

   task automatic st(input string tag, input logic [2:0] s, input logic [1:0] p);
      chk({tag, "_state"}, {1'b0, CurrentState}, {1'b0, s});
      chk({tag, "_step"}, {2'b0, step}, {2'b0, p});
   endtask

   initial begin
      cyc(3);
      st("reset", 3'b000, 2'd0);
      chk("reset_tick", {3'b0, tick}, 4'h0);
      chk("reset_swdb", {2'b0, dut.sw_db}, 4'h0);
      reset = 1'b0;
      cyc(6);
      chk("presc_before", {3'b0, tick}, 4'h0);
      cyc(1);
      chk("presc_tick", {3'b0, tick}, 4'h1);
      cyc(1);
      chk("presc_pulse", {3'b0, tick}, 4'h0);

      SW = 2'b01;
      cyc(5);
      chk("lat_5", {2'b0, dut.sw_db}, 4'h0);
      cyc(1);
      chk("lat_6", {2'b0, dut.sw_db}, 4'h1);
      to_tick("left_in");
      st("left_in", 3'b010, 2'd0);
      for (int k = 1; k <= 4; k++) begin
         to_tick("left_seq");
         st("left_seq", 3'b010, 2'(k % 4));
      end
      to_tick("left_s1");
      st("left_s1", 3'b010, 2'd1);

      SW = 2'b10;
      cyc(7);
      to_tick("swap_a");
      st("swap_a", 3'b010, 2'd2);
      to_tick("swap_b");
      st("swap_b", 3'b010, 2'd3);
      to_tick("swap_c");
      st("swap_c", 3'b011, 2'd0);
      to_tick("right_s1");
      st("right_s1", 3'b011, 2'd1);

      SW = 2'b11;
      cyc(7);
      to_tick("haz");
      st("haz", 3'b001, 2'd0);
      SW = 2'b00;
      cyc(7);
      to_tick("haz_off");
      st("haz_off", 3'b000, 2'd0);

      SW = 2'b01;
      cyc(3);
      SW = 2'b00;
      cyc(10);
      chk("glitch_swdb", {2'b0, dut.sw_db}, 4'h0);
      to_tick("glitch_a");
      st("glitch_a", 3'b000, 2'd0);
      to_tick("glitch_b");
      st("glitch_b", 3'b000, 2'd0);

      SW = 2'b01;
      cyc(7);
      to_tick("rst_pre_a");
      to_tick("rst_pre_b");
      st("rst_pre", 3'b010, 2'd1);
      for (int i = 0; i < 20 && !tick; i++) cyc(1);
      chk("rst_tick_hi", {3'b0, tick}, 4'h1);
      #2 reset = 1'b1;
      #1;
      st("rst_async", 3'b000, 2'd0);
      chk("rst_async_tick", {3'b0, tick}, 4'h0);
      chk("rst_async_swdb", {2'b0, dut.sw_db}, 4'h0);
      SW = 2'b00;
      cyc(2);
      reset = 1'b0;

      SW = 2'b01;
      cyc(7);
      to_tick("to_in");
      st("to_in", 3'b010, 2'd0);
      for (int k = 1; k <= 7; k++) to_tick("to_run");
      st("to_run", 3'b010, 2'd3);
      to_tick("to_end");
`ifdef TSC_TIMEOUT_EN
      st("to_end", 3'b000, 2'd0);
      to_tick("to_lock_a");
      to_tick("to_lock_b");
      st("to_lock", 3'b000, 2'd0);
      SW = 2'b00;
      cyc(7);
      to_tick("to_idle");
      st("to_idle", 3'b000, 2'd0);
      SW = 2'b01;
      cyc(7);
      to_tick("to_rearm");
      st("to_rearm", 3'b010, 2'd0);
`else
      st("to_end", 3'b010, 2'd0);
      to_tick("persist_a");
      to_tick("persist_b");
      st("persist", 3'b010, 2'd2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
